instr_assembler: RTL

- Field-level instruction encoder and program buffer for the multi-cycle 8-bit MIPS-subset core.
- Accepts decoded instruction fields (op, rs, rt, rd, imm) over a valid/ready handshake and encodes them into 32-bit MIPS words: addu, subu, addiu.
- Stores the words in a small program buffer that the core's fetch state reads by address.
- Sits on the opposite side of the core's decode stage: this block encodes what the core decodes.

---
 rtl/instr_assembler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/instr_assembler.sv
// Field-level MIPS encoder (addu/subu/addiu) feeding a small program buffer
// that the core's fetch state reads by address.
module instr_assembler #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic              in_last,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [31:0]       fetch_data,
   output logic [ADDR_W:0]   prog_len,
   output logic              prog_done,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_ACCEPT,
      ST_ENCODE,
      ST_WRITE,
      ST_SEALED
   } state_t;

   typedef enum logic [1:0] {
      OP_ADDU,
      OP_SUBU,
      OP_ADDIU,
      OP_ILLEGAL
   } op_t;

   localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);

   state_t            state;
   state_t            state_nxt;

   logic              take;
   logic              set_err;
   logic              enc_load;
   logic              store;

   op_t               lat_op;
   logic [4:0]        lat_rs;
   logic [4:0]        lat_rt;
   logic [4:0]        lat_rd;
   logic [15:0]       lat_imm;
   logic              lat_last;

   logic [31:0]       enc;
   logic [31:0]       enc_word;
   logic [ADDR_W:0]   len_inc;
   logic [ADDR_W-1:0] wr_ptr;

   logic [31:0]       mem [DEPTH];

   assign len_inc   = prog_len + LEN_ONE;
   assign wr_ptr    = prog_len[ADDR_W-1:0];
   assign prog_done = (state == ST_SEALED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ACCEPT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      take      = 1'b0;
      set_err   = 1'b0;
      enc_load  = 1'b0;
      store     = 1'b0;
      unique case (state)
         ST_ACCEPT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               take = 1'b1;
               if (op_t'(in_op) == OP_ILLEGAL) begin
                  set_err   = 1'b1;
                  state_nxt = in_last ? ST_SEALED : ST_ACCEPT;
               end else begin
                  state_nxt = ST_ENCODE;
               end
            end
         end
         ST_ENCODE: begin
            enc_load  = 1'b1;
            state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            store     = 1'b1;
            state_nxt = (lat_last || (len_inc == LEN_FULL)) ? ST_SEALED : ST_ACCEPT;
         end
         ST_SEALED: begin
            state_nxt = ST_SEALED;
         end
      endcase
      // clear wins over any handshake or write happening in the same cycle
      if (clear) begin
         state_nxt = ST_ACCEPT;
         take      = 1'b0;
         set_err   = 1'b0;
         enc_load  = 1'b0;
         store     = 1'b0;
      end
   end

   always_comb begin
      enc_word = '0;
      case (lat_op)
         OP_ADDU:  enc_word = {6'b000000, lat_rs, lat_rt, lat_rd, 5'b00000, 6'b100001};
         OP_SUBU:  enc_word = {6'b000000, lat_rs, lat_rt, lat_rd, 5'b00000, 6'b100011};
         OP_ADDIU: enc_word = {6'b001001, lat_rs, lat_rt, lat_imm};
         default:  enc_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_op     <= OP_ADDU;
         lat_rs     <= '0;
         lat_rt     <= '0;
         lat_rd     <= '0;
         lat_imm    <= '0;
         lat_last   <= 1'b0;
         enc        <= '0;
         prog_len   <= '0;
         err        <= 1'b0;
         fetch_data <= '0;
      end else begin
         if (take) begin
            lat_op   <= op_t'(in_op);
            lat_rs   <= in_rs;
            lat_rt   <= in_rt;
            lat_rd   <= in_rd;
            lat_imm  <= in_imm;
            lat_last <= in_last;
         end
         if (enc_load) begin
            enc <= enc_word;
         end
         if (clear) begin
            prog_len <= '0;
         end else if (store) begin
            prog_len <= len_inc;
         end
         if (clear) begin
            err <= 1'b0;
         end else if (set_err) begin
            err <= 1'b1;
         end
         // the entry being written this cycle is still beyond prog_len, so it reads as nop
         fetch_data <= ({1'b0, fetch_addr} < prog_len) ? mem[fetch_addr] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         mem[wr_ptr] <= enc;
      end
   end

endmodule
